// File: rtl/mio_bus_responder.sv
`timescale 1ns/1ps
// Memory/IO bus responder for the single-cycle CPU: word RAM, LED register,
// switch input and cycle counter behind a per-region wait-state handshake.
module mio_bus_responder #(
  parameter int RAM_AW   = 8,
  parameter int RAM_WAIT = 2,
  parameter int IO_WAIT  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] addr_bus,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  output logic        bus_err,
  input  logic [7:0]  sw_in,
  output logic [7:0]  led_out
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef enum logic [2:0] {R_RAM, R_LED, R_SW, R_CNT, R_NONE} region_t;

  localparam logic [3:0] RAM_W = 4'(RAM_WAIT);
  localparam logic [3:0] IO_W  = 4'(IO_WAIT);

  function automatic region_t decode(input logic [31:0] a);
    region_t r;
    if (a[31:RAM_AW+2] == '0) begin
      r = R_RAM;
    end else begin
      case (a[31:2])
        30'h3C00_0000: r = R_LED;
        30'h3C00_0001: r = R_SW;
        30'h3C00_0002: r = R_CNT;
        default:       r = R_NONE;
      endcase
    end
    return r;
  endfunction

  state_t              state;
  region_t             region_q;
  logic                we_q;
  logic [31:0]         wdata_q;
  logic [RAM_AW-1:0]   idx_q;
  logic [3:0]          wait_cnt;
  logic [31:0]         counter;
  logic [31:0]         mem [0:(1<<RAM_AW)-1];

  region_t             req_region;
  region_t             c_region;
  logic [3:0]          req_wait;
  logic                accept;
  logic                commit;
  logic                c_we;
  logic [31:0]         c_wdata;
  logic [RAM_AW-1:0]   c_idx;
  logic [31:0]         rd_data;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^addr_bus[1:0];

  assign req_region = decode(addr_bus);
  assign req_wait   = (req_region == R_RAM) ? RAM_W : IO_W;
  assign accept     = (state == S_IDLE) && CPU_MIO;

  // With zero wait states the access commits on the acceptance edge itself,
  // so the commit operands come straight from the bus instead of the latches.
  assign commit   = (accept && (req_wait == 4'd0)) ||
                    ((state == S_WAIT) && (wait_cnt == 4'd1));
  assign c_region = accept ? req_region : region_q;
  assign c_we     = accept ? mem_w : we_q;
  assign c_wdata  = accept ? Data_out : wdata_q;
  assign c_idx    = accept ? addr_bus[RAM_AW+1:2] : idx_q;

  always_comb begin
    rd_data = 32'h0;
    case (c_region)
      R_RAM:   rd_data = mem[c_idx];
      R_LED:   rd_data = {24'h0, led_out};
      R_SW:    rd_data = {24'h0, sw_in};
      R_CNT:   rd_data = counter;
      default: rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && commit && c_we && (c_region == R_RAM)) begin
      mem[c_idx] <= c_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      region_q  <= R_NONE;
      we_q      <= 1'b0;
      wdata_q   <= 32'h0;
      idx_q     <= '0;
      wait_cnt  <= 4'd0;
      counter   <= 32'h0;
      led_out   <= 8'h0;
      Data_in   <= 32'h0;
      MIO_ready <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      counter   <= counter + 32'd1;
      MIO_ready <= 1'b0;
      bus_err   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (CPU_MIO) begin
            region_q <= req_region;
            we_q     <= mem_w;
            wdata_q  <= Data_out;
            idx_q    <= addr_bus[RAM_AW+1:2];
            wait_cnt <= req_wait;
            state    <= (req_wait == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // A counter write on the commit edge overrides the increment above.
      if (commit) begin
        MIO_ready <= 1'b1;
        bus_err   <= (c_region == R_NONE);
        if (c_we) begin
          if (c_region == R_LED) led_out <= c_wdata[7:0];
          if (c_region == R_CNT) counter <= c_wdata;
        end else begin
          Data_in <= rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
`timescale 1ns/1ps
// Self-checking bench for mio_bus_responder: directed scenarios plus random
// traffic compared every cycle against a transaction-level model.
module tb_mio_bus_responder;

  localparam int RAM_AW   = 8;
  localparam int RAM_WAIT = 2;
  localparam int IO_WAIT  = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CPU_MIO = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] addr_bus = 32'h0;
  logic [31:0] Data_out = 32'h0;
  logic [31:0] Data_in;
  logic        MIO_ready;
  logic        bus_err;
  logic [7:0]  sw_in = 8'h0;
  logic [7:0]  led_out;

  int checks = 0;
  int errors = 0;

  mio_bus_responder #(
    .RAM_AW(RAM_AW), .RAM_WAIT(RAM_WAIT), .IO_WAIT(IO_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
    .addr_bus(addr_bus), .Data_out(Data_out), .Data_in(Data_in),
    .MIO_ready(MIO_ready), .bus_err(bus_err), .sw_in(sw_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // 0 RAM, 1 LED, 2 switches, 3 counter, 4 unmapped
  function automatic int region_of(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'd3;
    if (a < (32'd4 << RAM_AW)) return 0;
    if (w == 32'hF000_0000) return 1;
    if (w == 32'hF000_0004) return 2;
    if (w == 32'hF000_0008) return 3;
    return 4;
  endfunction

  function automatic int wait_of(input int r);
    return (r == 0) ? RAM_WAIT : IO_WAIT;
  endfunction

  // Transaction-level model: edges are numbered from reset; a request accepted
  // at edge k commits at edge k+W and the next one may be taken from k+W+2.
  longint      k;
  longint      m_commit_edge;
  longint      m_next_ok;
  bit          m_busy;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  bit   [31:0] m_cnt;
  bit   [31:0] pre_cnt;
  bit   [7:0]  m_led;
  bit   [31:0] m_mem [int];
  int          m_r;
  int          m_idx;
  bit          exp_ready;
  bit          exp_err;
  bit          exp_chk;
  bit   [31:0] exp_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; m_busy = 0; m_next_ok = 0; m_commit_edge = -1;
      m_cnt = 0; m_led = 0;
      exp_ready = 0; exp_err = 0; exp_chk = 0; exp_rdata = 0;
    end else begin
      pre_cnt = m_cnt;
      m_cnt = m_cnt + 1;
      if (!m_busy && CPU_MIO && k >= m_next_ok) begin
        m_busy = 1; m_we = mem_w; m_addr = addr_bus; m_data = Data_out;
        m_commit_edge = k + wait_of(region_of(addr_bus));
        m_next_ok = m_commit_edge + 2;
      end
      exp_ready = 0; exp_err = 0; exp_chk = 0;
      if (m_busy && k == m_commit_edge) begin
        m_busy = 0;
        exp_ready = 1;
        m_r = region_of(m_addr);
        m_idx = int'((m_addr >> 2) & ((32'd1 << RAM_AW) - 1));
        exp_err = (m_r == 4);
        if (m_we) begin
          if (m_r == 0) m_mem[m_idx] = m_data;
          if (m_r == 1) m_led = m_data[7:0];
          if (m_r == 3) m_cnt = m_data;
        end else begin
          exp_chk = 1;
          case (m_r)
            0: if (m_mem.exists(m_idx)) exp_rdata = m_mem[m_idx]; else exp_chk = 0;
            1: exp_rdata = {24'h0, m_led};
            2: exp_rdata = {24'h0, sw_in};
            3: exp_rdata = pre_cnt;
            default: exp_rdata = 32'h0;
          endcase
        end
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cyc_ready", MIO_ready, exp_ready);
      checkOutput("cyc_bus_err", bus_err, exp_err);
      checkOutput("cyc_led", led_out, m_led);
      if (exp_ready && exp_chk) checkOutput("cyc_rdata", Data_in, exp_rdata);
    end
  end

  bit         sw_rand = 1;
  logic [7:0] sw_fixed = 8'h0;
  always @(negedge clk) sw_in = sw_rand ? 8'($urandom) : sw_fixed;

  int pulses = 0;
  always @(negedge clk) if (MIO_ready) pulses++;

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                               input bit drop, output logic [31:0] rdata, output int lat,
                               output logic err);
    @(negedge clk);
    CPU_MIO = 1'b1; mem_w = we; addr_bus = addr; Data_out = data;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        addr_bus = $urandom; Data_out = $urandom; mem_w = 1'($urandom);
        if (drop) CPU_MIO = 1'b0;
      end
    end while (!MIO_ready && lat < 40);
    checkOutput("handshake", MIO_ready, 1'b1);
    rdata = Data_in; err = bus_err;
    CPU_MIO = 1'b0; mem_w = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          n;
  int          p0;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_ready", MIO_ready, 1'b0);
    checkOutput("reset_data_in", Data_in, 32'h0);
    checkOutput("reset_bus_err", bus_err, 1'b0);
    checkOutput("reset_led", led_out, 8'h0);
    @(negedge clk); #2 rst_n = 1'b1;

    applyStimulus(1'b1, 32'h10, 32'hCAFE_BABE, 0, rd, lat, er);
    checkOutput("ram_wr_lat", lat, 3);
    applyStimulus(1'b0, 32'h10, 32'h0, 0, rd, lat, er);
    checkOutput("ram_rd_lat", lat, 3);
    checkOutput("ram_rd_data", rd, 32'hCAFE_BABE);
    checkOutput("ram_rd_err", er, 1'b0);

    applyStimulus(1'b1, 32'hF000_0000, 32'h0000_01A5, 0, rd, lat, er);
    checkOutput("led_wr_lat", lat, 1);
    checkOutput("led_value", led_out, 8'hA5);
    applyStimulus(1'b0, 32'hF000_0000, 32'h0, 0, rd, lat, er);
    checkOutput("led_rd_data", rd, 32'h0000_00A5);
    sw_fixed = 8'h3C; sw_rand = 0;
    @(negedge clk);
    applyStimulus(1'b0, 32'hF000_0004, 32'h0, 0, rd, lat, er);
    checkOutput("sw_rd_data", rd, 32'h0000_003C);
    checkOutput("sw_rd_lat", lat, 1);
    sw_rand = 1;

    applyStimulus(1'b1, 32'hF000_0008, 32'hFFFF_FFFE, 0, rd, lat, er);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 32'hF000_0008, 32'h0, 0, rd, lat, er);
    checkOutput("cnt_wrap", rd, 32'h0000_0001);

    applyStimulus(1'b0, 32'h1000_0000, 32'h0, 0, rd, lat, er);
    checkOutput("unmapped_rd_data", rd, 32'h0);
    checkOutput("unmapped_rd_err", er, 1'b1);
    checkOutput("unmapped_rd_lat", lat, 1);
    @(negedge clk);
    checkOutput("bus_err_after", bus_err, 1'b0);
    applyStimulus(1'b1, 32'h1000_0000, 32'hFFFF_FFFF, 0, rd, lat, er);
    checkOutput("unmapped_wr_err", er, 1'b1);
    checkOutput("unmapped_wr_led", led_out, 8'hA5);
    applyStimulus(1'b0, 32'h10, 32'h0, 0, rd, lat, er);
    checkOutput("ram_kept", rd, 32'hCAFE_BABE);

    // CPU_MIO held high across two RAM writes
    @(negedge clk);
    p0 = pulses;
    CPU_MIO = 1'b1; mem_w = 1'b1; addr_bus = 32'h40; Data_out = 32'h1111_AAAA;
    n = 0;
    do begin @(negedge clk); n++; end while (!MIO_ready && n < 40);
    addr_bus = 32'h44; Data_out = 32'h2222_BBBB;
    n = 0;
    do begin @(negedge clk); n++; end while (!MIO_ready && n < 40);
    checkOutput("b2b_gap", n, 4);
    CPU_MIO = 1'b0; mem_w = 1'b0;
    repeat (4) @(negedge clk);
    #1 checkOutput("b2b_pulses", pulses - p0, 2);
    applyStimulus(1'b0, 32'h40, 32'h0, 0, rd, lat, er);
    checkOutput("b2b_word0", rd, 32'h1111_AAAA);
    applyStimulus(1'b0, 32'h44, 32'h0, 0, rd, lat, er);
    checkOutput("b2b_word1", rd, 32'h2222_BBBB);

    // Reset during the WAIT of a RAM write
    applyStimulus(1'b1, 32'h20, 32'h0, 0, rd, lat, er);
    @(negedge clk);
    CPU_MIO = 1'b1; mem_w = 1'b1; addr_bus = 32'h20; Data_out = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    p0 = pulses;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_ready", MIO_ready, 1'b0);
    checkOutput("rst_mid_data_in", Data_in, 32'h0);
    checkOutput("rst_mid_bus_err", bus_err, 1'b0);
    checkOutput("rst_mid_led", led_out, 8'h0);
    CPU_MIO = 1'b0; mem_w = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 checkOutput("rst_mid_no_pulse", pulses - p0, 0);
    applyStimulus(1'b0, 32'h20, 32'h0, 0, rd, lat, er);
    checkOutput("rst_lost_write", rd, 32'h0);
    applyStimulus(1'b0, 32'hF000_0008, 32'h0, 0, rd, lat, er);
    checkOutput("rst_cnt_small", rd < 32'd16, 1'b1);
    checkOutput("rst_led_clear", led_out, 8'h0);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      int          sel;
      int          exp_lat;
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1, 2, 3: a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        4:          a = 32'hF000_0000 | 32'($urandom_range(0, 3));
        5:          a = 32'hF000_0004 | 32'($urandom_range(0, 3));
        6:          a = 32'hF000_0008 | 32'($urandom_range(0, 3));
        default:    a = 32'h0001_0000 + 32'($urandom_range(0, 1000)) * 4;
      endcase
      exp_lat = wait_of(region_of(a)) + 1;
      applyStimulus(1'($urandom), a, $urandom, ($urandom_range(0, 7) == 0), rd, lat, er);
      checkOutput("rand_lat", lat, exp_lat);
      checkOutput("rand_err", er, region_of(a) == 4);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mio_bus_responder.md
# mio_bus_responder

Memory/IO bus responder for the single-cycle CPU: it services the requests the CPU controller raises on `CPU_MIO` / `mem_w` and answers with `MIO_ready` plus read data. It sits between the CPU datapath and the board: a word-addressed data RAM, an LED register, a switch input and a free-running cycle counter. Wait states are inserted per region, so the CPU stalls until `MIO_ready` arrives.

## Interface

Parameters:
- `RAM_AW`, 8: RAM word-address width; RAM holds 2^RAM_AW 32-bit words.
- `RAM_WAIT`, 2: wait cycles for RAM accesses (0..15).
- `IO_WAIT`, 0: wait cycles for IO and unmapped accesses (0..15).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `CPU_MIO`  in  1  request valid; held by the CPU until `MIO_ready`.
- `mem_w`  in  1  1 = write, 0 = read; qualified by `CPU_MIO`.
- `addr_bus`  in  32  byte address; `addr_bus[1:0]` ignored (word access only).
- `Data_out`  in  32  CPU write data.
- `Data_in`  out  32  read data to the CPU; valid while `MIO_ready`=1.
- `MIO_ready`  out  1  one-cycle completion pulse.
- `bus_err`  out  1  pulses with `MIO_ready` when the address is unmapped.
- `sw_in`  in  8  board switches; treated as synchronous.
- `led_out`  out  8  LED register.

One clock; reset is asynchronous and active-low.

## Operation

- Address map:
  - RAM: `addr_bus < 4*2^RAM_AW`, word index `addr_bus[RAM_AW+1:2]`.
  - 0xF000_0000: LED. A write loads `Data_out[7:0]`; a read returns the LED value zero-extended.
  - 0xF000_0004: switches. A read returns `sw_in` zero-extended; writes are ignored with no error.
  - 0xF000_0008: cycle counter. A read returns the counter; a write loads it.
  - Any other address: unmapped. Reads return 0, writes are dropped, `bus_err`=1 with `MIO_ready`.
- FSM has 3 states: IDLE, WAIT, RESP.
  - IDLE, `CPU_MIO`=1 at an edge: latch `addr_bus`, `Data_out` and `mem_w`, and decode the region. Load the wait counter with W (`RAM_WAIT` for RAM, `IO_WAIT` otherwise). Go to WAIT if W>0, else RESP.
  - WAIT: decrement each edge; on the edge where the counter reaches 0, go to RESP.
  - RESP: `MIO_ready`=1 for exactly one cycle, then IDLE unconditionally.
  - A request is not accepted on the edge leaving RESP, so one CPU transaction is never serviced twice.
- The access commits on the edge entering RESP, using the latched values: RAM or register write, or registered `Data_in` capture. Read-after-write to the same address in the next transaction returns the new data.
- Counter: 32-bit, +1 every cycle, wraps 0xFFFF_FFFF→0. A write on the same edge wins over the increment (counter = written value). A read returns the pre-increment value sampled at the commit edge.
- `CPU_MIO` dropping during WAIT is a protocol violation; the latched transaction still completes and pulses `MIO_ready`.
- Input changes after acceptance are ignored; the latched values are used.

## Timing

- Reset values: state IDLE, `MIO_ready`=0, `Data_in`=0, `bus_err`=0, `led_out`=0, counter=0. RAM is not reset (contents undefined).
- Latency: request sampled at end of cycle 0. Cycles 1..W are WAIT with `MIO_ready`=0. Cycle W+1 is RESP with `MIO_ready`=1 and `Data_in` valid.
  - RAM with default parameters: ready in cycle 3.
  - IO with default parameters: ready in cycle 1.
- Back-to-back: minimum spacing between accepted requests is W+2 cycles. The earliest next acceptance is at the end of the cycle after RESP.
- `Data_in` holds its last value outside RESP. `bus_err` is 0 outside RESP.
- Reset asserted mid-transaction: immediate return to reset values. A write not yet at its commit edge is lost. The counter and LED clear.

## Test plan

- Reset, then RAM write 0x0000_0010 ← 0xCAFEBABE, then read back → `MIO_ready` in cycle 3 of each transaction; read `Data_in`=0xCAFEBABE, `bus_err`=0.
- Write 0xF000_0000 ← 0x0000_01A5 → `led_out`=0xA5 after the ready cycle; read back returns 0x0000_00A5; `sw_in`=0x3C read at 0xF000_0004 returns 0x0000_003C, ready in cycle 1.
- Write counter 0xFFFF_FFFE, then read at the next accepted request → value = 0xFFFF_FFFE + elapsed cycles mod 2^32, demonstrating wrap to small values.
- Read 0x1000_0000 (unmapped) → `Data_in`=0, `bus_err`=1 only in the `MIO_ready` cycle; a write there changes no state.
- `CPU_MIO` held high continuously across two RAM writes to different addresses → exactly two `MIO_ready` pulses 4 cycles apart, both words stored, no duplicate.
- Assert `rst_n`=0 during WAIT of a RAM write of 0x12345678 to 0x0000_0020 → outputs return to reset values immediately and no `MIO_ready` pulse occurs. Read-back from that address must not return 0x12345678 (preload it with 0x0 first).
